tx_config: RTL and testbench
============================

TX_CONFIG -- requirements
Module: tx_config

Interface
REQ-001 Parameter PE_NUM, default 32, number of PE output-buffer slices addressed by the mask.
REQ-002 Parameter INST_W, default 64, instruction word width.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 layer_type  input  4  global layer-type register; bit0 selects single-PE (1) or 4-PE-group (0) masking.
REQ-006 ins_valid / ins_ready / ins  input / output / INST_W  write-back instruction handshake.
REQ-007 obuf_conf_valid / obuf_conf_ready  output / input  1 each  output-buffer drain configuration handshake.
REQ-008 obuf_conf_mode  output  4  latched layer_type; obuf_conf_mask  output  PE_NUM  PE select; obuf_conf_trans_num  output  16  beats to drain.
REQ-009 ddr_wr_cmd_valid / ddr_wr_cmd_ready  output / input  1 each  DDR write-command handshake.
REQ-010 ddr_wr_addr  output  32  start address; ddr_wr_len  output  16  beat count.
REQ-011 ddr_wr_beat  input  1  one-cycle strobe per data beat accepted by DDR.
REQ-012 tx_done_pulse  output  1  completion strobe; tx_done_opcode  output  4; tx_done_buf_id  output  6.
REQ-013 tx_error  output  1  sticky watchdog flag (see Configuration).

Function
REQ-014 Decode: opcode=ins[61:58], buf_id=ins[57:52], trans=ins[51:40] zero-extended to 16 bits, st_addr=ins[31:0]; all fields latched on ins handshake.
REQ-015 Mask = layer_type[0] ? (1<<buf_id) : (15<<(buf_id*4)), truncated to PE_NUM bits; bits shifted beyond PE_NUM are dropped, no error.
REQ-016 States: IDLE, CONF, WORK, DONE; ins_ready=1 only in IDLE.
REQ-017 IDLE: on ins_valid&&ins_ready go CONF if trans!=0, else go DONE directly with no conf/cmd issued.
REQ-018 CONF: obuf_conf_valid and ddr_wr_cmd_valid both rise the cycle after the ins handshake; each drops the cycle after its own ready is sampled high; order of the two readies is free, including same cycle.
REQ-019 Leave CONF for WORK the cycle after both handshakes complete; payload outputs stay stable while the respective valid is high.
REQ-020 16-bit beat counter clears on ins handshake, increments on ddr_wr_beat in CONF or WORK; beats in IDLE or DONE ignored.
REQ-021 WORK to DONE when counter equals trans (including a count reached during CONF); beats beyond trans are ignored.
REQ-022 DONE lasts exactly one cycle: tx_done_pulse=1, tx_done_opcode/buf_id show latched values; next state IDLE.
REQ-023 Latency: final beat at cycle N -> tx_done_pulse at N+1 -> ins_ready=1 at N+2.
REQ-024 tx_done_opcode/buf_id hold their values until the next ins handshake.

Reset
REQ-025 On rst: state IDLE, ins_ready=1, every valid, tx_done_pulse, tx_error, counter and all payload outputs 0.
REQ-026 rst mid-operation abandons the transfer silently: no tx_done_pulse and no further valid assertions.

Configuration
REQ-027 Macro TX_TIMEOUT_EN: when defined, a 10-bit idle counter runs in WORK, clears on each ddr_wr_beat, and at 1023 forces DONE and sets tx_error until rst.
REQ-028 Without TX_TIMEOUT_EN: no watchdog logic, tx_error tied 0, and WORK waits indefinitely.

Verification
REQ-029 layer_type=1, ins buf_id=5, trans=8, addr=0x1000 -> mask=0x20, trans_num=8, len=8, addr=0x1000; 8 beats -> one tx_done_pulse with buf_id=5.
REQ-030 layer_type=0, buf_id=7 -> mask=0xF0000000; buf_id=8 -> mask=0.
REQ-031 trans=0 -> no conf/cmd valid; tx_done_pulse 1 cycle after handshake; ins_ready high 2 cycles after handshake.
REQ-032 ddr_wr_cmd_ready 3 cycles before obuf_conf_ready, and 2 beats arriving during CONF with trans=2 -> WORK then DONE immediately, a single pulse.
REQ-033 rst asserted after 3 of 8 beats -> no pulse, ins_ready=1; a new instruction completes normally.
REQ-034 With TX_TIMEOUT_EN and no beats in WORK for 1023 cycles -> tx_done_pulse and tx_error=1; without the macro -> FSM still in WORK.

Source files
------------

// File: rtl/tx_config.sv
// ---------------------------------------------------------------------------
// tx_config
//
// Decodes a write-back instruction and drives two independent handshakes:
// an output-buffer drain configuration (which PE slices to drain and how many
// beats) and a DDR write command (start address and length). It then counts
// the data beats the DDR side accepts. After the last beat it emits a
// one-cycle completion strobe carrying the instruction's opcode and buffer id.
//
// Parameters
//   PE_NUM  number of PE output-buffer slices addressed by the mask
//   INST_W  instruction word width (fields live in bits 61:0)
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   layer_type[3:0]                   global layer type; bit0 = single-PE mask
//   ins_valid / ins_ready / ins       instruction handshake
//   obuf_conf_valid / obuf_conf_ready output-buffer configuration handshake
//   obuf_conf_mode / _mask / _trans_num   configuration payload
//   ddr_wr_cmd_valid / ddr_wr_cmd_ready   DDR write-command handshake
//   ddr_wr_addr / ddr_wr_len              DDR command payload
//   ddr_wr_beat                       one-cycle strobe per accepted data beat
//   tx_done_pulse / _opcode / _buf_id completion strobe and its tags
//   tx_error                          sticky watchdog flag
//
// Build option
//   TX_TIMEOUT_EN  when defined, a 10-bit watchdog aborts a WORK phase that
//                  sees no beat for 1023 cycles and raises tx_error. When it
//                  is undefined, tx_error is tied low and WORK waits forever.
// ---------------------------------------------------------------------------
module tx_config #(
   parameter int PE_NUM = 32,
   parameter int INST_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        layer_type,
   input  logic              ins_valid,
   output logic              ins_ready,
   input  logic [INST_W-1:0] ins,
   output logic              obuf_conf_valid,
   input  logic              obuf_conf_ready,
   output logic [3:0]        obuf_conf_mode,
   output logic [PE_NUM-1:0] obuf_conf_mask,
   output logic [15:0]       obuf_conf_trans_num,
   output logic              ddr_wr_cmd_valid,
   input  logic              ddr_wr_cmd_ready,
   output logic [31:0]       ddr_wr_addr,
   output logic [15:0]       ddr_wr_len,
   input  logic              ddr_wr_beat,
   output logic              tx_done_pulse,
   output logic [3:0]        tx_done_opcode,
   output logic [5:0]        tx_done_buf_id,
   output logic              tx_error
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONF = 2'd1;
   localparam logic [1:0] S_WORK = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [15:0]       trans_q;
   logic [15:0]       beat_cnt;

   logic [3:0]        dec_opcode;
   logic [5:0]        dec_buf_id;
   logic [15:0]       dec_trans;
   logic [31:0]       dec_addr;
   logic [7:0]        group_shift;
   logic [PE_NUM-1:0] dec_mask;

   logic              ins_hs;
   logic              conf_hs;
   logic              cmd_hs;
   logic              conf_clear;
   logic              cmd_clear;
   logic              beat_take;
   logic              beat_final;
   logic              timeout_hit;

   // Instruction bits outside the decoded fields carry nothing for this block.
   logic              unused_ins_bits;
   assign unused_ins_bits = ^{ins[INST_W-1:62], ins[39:32]};

   // Field decode straight off the instruction bus; only sampled on handshake.
   assign dec_opcode  = ins[61:58];
   assign dec_buf_id  = ins[57:52];
   assign dec_trans   = {4'd0, ins[51:40]};
   assign dec_addr    = ins[31:0];

   // Single-PE mode selects one slice, group mode selects four adjacent
   // slices. Shift amounts at or beyond PE_NUM simply shift the bits out,
   // so large buffer ids yield an empty mask rather than an error.
   assign group_shift = {dec_buf_id, 2'b00};
   assign dec_mask    = layer_type[0] ? ({{(PE_NUM-1){1'b0}}, 1'b1} << dec_buf_id)
                                      : (PE_NUM'(4'hF) << group_shift);

   assign ins_ready     = (state == S_IDLE);
   assign tx_done_pulse = (state == S_DONE);

   assign ins_hs  = ins_valid && ins_ready;
   assign conf_hs = obuf_conf_valid && obuf_conf_ready;
   assign cmd_hs  = ddr_wr_cmd_valid && ddr_wr_cmd_ready;

   // A handshake counts as finished once its valid is low or it completes
   // on this edge, so both orders and the same-cycle case leave CONF together.
   assign conf_clear = !obuf_conf_valid || conf_hs;
   assign cmd_clear  = !ddr_wr_cmd_valid || cmd_hs;

   // Beats count only while a transfer is live and saturate at the target,
   // so extra beats can never push the counter past the completion point.
   assign beat_take  = ddr_wr_beat && ((state == S_CONF) || (state == S_WORK))
                       && (beat_cnt != trans_q);
   assign beat_final = (beat_cnt == trans_q)
                       || (beat_take && ((beat_cnt + 16'd1) == trans_q));

   assign obuf_conf_trans_num = trans_q;
   assign ddr_wr_len          = trans_q;

   // Next-state logic. A zero-length instruction skips straight to DONE so
   // the requester still gets its completion strobe.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (ins_hs) begin
               state_next = (dec_trans != 16'd0) ? S_CONF : S_DONE;
            end
         end
         S_CONF: begin
            if (conf_clear && cmd_clear) begin
               state_next = S_WORK;
            end
         end
         S_WORK: begin
            if (beat_final || timeout_hit) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State, latched instruction fields, handshake valids and beat counter.
   // Payload registers only change on an instruction handshake, which keeps
   // them stable for as long as either valid is raised.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         trans_q          <= 16'd0;
         beat_cnt         <= 16'd0;
         obuf_conf_valid  <= 1'b0;
         ddr_wr_cmd_valid <= 1'b0;
         obuf_conf_mode   <= 4'd0;
         obuf_conf_mask   <= '0;
         ddr_wr_addr      <= 32'd0;
         tx_done_opcode   <= 4'd0;
         tx_done_buf_id   <= 6'd0;
      end else begin
         state <= state_next;
         if (ins_hs) begin
            trans_q          <= dec_trans;
            beat_cnt         <= 16'd0;
            obuf_conf_valid  <= (dec_trans != 16'd0);
            ddr_wr_cmd_valid <= (dec_trans != 16'd0);
            obuf_conf_mode   <= layer_type;
            obuf_conf_mask   <= dec_mask;
            ddr_wr_addr      <= dec_addr;
            tx_done_opcode   <= dec_opcode;
            tx_done_buf_id   <= dec_buf_id;
         end else begin
            if (conf_hs) begin
               obuf_conf_valid <= 1'b0;
            end
            if (cmd_hs) begin
               ddr_wr_cmd_valid <= 1'b0;
            end
            if (beat_take) begin
               beat_cnt <= beat_cnt + 16'd1;
            end
         end
      end
   end

`ifdef TX_TIMEOUT_EN
   logic [9:0] idle_cnt;
   logic       error_q;

   assign timeout_hit = (state == S_WORK) && (idle_cnt == 10'h3FF);
   assign tx_error    = error_q;

   // Watchdog: counts beat-free WORK cycles; on expiry the transfer is
   // closed out through DONE and the error stays set until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= 10'd0;
         error_q  <= 1'b0;
      end else if (state == S_WORK) begin
         if (timeout_hit) begin
            idle_cnt <= 10'd0;
            error_q  <= 1'b1;
         end else if (ddr_wr_beat) begin
            idle_cnt <= 10'd0;
         end else begin
            idle_cnt <= idle_cnt + 10'd1;
         end
      end else begin
         idle_cnt <= 10'd0;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign tx_error    = 1'b0;
`endif

endmodule

// File: tb/tb_tx_config.sv
// ---------------------------------------------------------------------------
// tb_tx_config
//
// Directed bench for tx_config. A transaction-level model records what each
// instruction must produce (mask, address, length, tags) and how many
// configuration/command handshakes and completion strobes the run must see.
// A per-cycle compare process checks payloads against that model whenever a
// valid or the done strobe is raised; directed tasks pin cycle timing.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tx_config;

   localparam int PE_NUM = 32;
   localparam int INST_W = 64;

   logic              clk;
   logic              rst;
   logic [3:0]        layer_type;
   logic              ins_valid;
   logic              ins_ready;
   logic [INST_W-1:0] ins;
   logic              obuf_conf_valid;
   logic              obuf_conf_ready;
   logic [3:0]        obuf_conf_mode;
   logic [PE_NUM-1:0] obuf_conf_mask;
   logic [15:0]       obuf_conf_trans_num;
   logic              ddr_wr_cmd_valid;
   logic              ddr_wr_cmd_ready;
   logic [31:0]       ddr_wr_addr;
   logic [15:0]       ddr_wr_len;
   logic              ddr_wr_beat;
   logic              tx_done_pulse;
   logic [3:0]        tx_done_opcode;
   logic [5:0]        tx_done_buf_id;
   logic              tx_error;

   tx_config #(.PE_NUM(PE_NUM), .INST_W(INST_W)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .layer_type          (layer_type),
      .ins_valid           (ins_valid),
      .ins_ready           (ins_ready),
      .ins                 (ins),
      .obuf_conf_valid     (obuf_conf_valid),
      .obuf_conf_ready     (obuf_conf_ready),
      .obuf_conf_mode      (obuf_conf_mode),
      .obuf_conf_mask      (obuf_conf_mask),
      .obuf_conf_trans_num (obuf_conf_trans_num),
      .ddr_wr_cmd_valid    (ddr_wr_cmd_valid),
      .ddr_wr_cmd_ready    (ddr_wr_cmd_ready),
      .ddr_wr_addr         (ddr_wr_addr),
      .ddr_wr_len          (ddr_wr_len),
      .ddr_wr_beat         (ddr_wr_beat),
      .tx_done_pulse       (tx_done_pulse),
      .tx_done_opcode      (tx_done_opcode),
      .tx_done_buf_id      (tx_done_buf_id),
      .tx_error            (tx_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Transaction model state.
   logic [3:0]        m_mode;
   logic [PE_NUM-1:0] m_mask;
   logic [15:0]       m_trans;
   logic [31:0]       m_addr;
   logic [3:0]        m_op;
   logic [5:0]        m_buf;
   logic              conf_allowed = 1'b0;
   logic              cmd_allowed  = 1'b0;
   logic              cmp_en       = 1'b0;
   int                exp_conf_hs  = 0;
   int                exp_cmd_hs   = 0;
   int                exp_pulses   = 0;
   int                conf_hs_seen = 0;
   int                cmd_hs_seen  = 0;
   int                pulse_seen   = 0;

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      total_cnt++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   // Mask computed in a very wide vector and then cut down to PE_NUM slices.
   function automatic logic [PE_NUM-1:0] model_mask(input logic single, input int b);
      logic [319:0] wide;
      if (single) wide = 320'd1 << b;
      else        wide = 320'd15 << (b * 4);
      return wide[PE_NUM-1:0];
   endfunction

   // Unused instruction bits are filled with junk so decoding must ignore them.
   function automatic logic [63:0] make_ins(input logic [3:0] op, input logic [5:0] b,
                                            input logic [11:0] t, input logic [31:0] a);
      logic [63:0] w;
      w        = '0;
      w[63:62] = 2'b11;
      w[61:58] = op;
      w[57:52] = b;
      w[51:40] = t;
      w[39:32] = 8'hA5;
      w[31:0]  = a;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction in an IDLE cycle; returns one cycle after the
   // handshake edge, just past the clock.
   task automatic apply_stimulus(input logic [3:0] lt, input logic [3:0] op,
                                 input logic [5:0] b, input logic [11:0] t,
                                 input logic [31:0] a);
      layer_type = lt;
      ins        = make_ins(op, b, t, a);
      ins_valid  = 1'b1;
      @(negedge clk);
      check_output("ready_before_ins", ins_ready, 1);
      m_mode  = lt;
      m_mask  = model_mask(lt[0], int'(b));
      m_trans = {4'd0, t};
      m_addr  = a;
      m_op    = op;
      m_buf   = b;
      if (t != 12'd0) begin
         conf_allowed = 1'b1;
         cmd_allowed  = 1'b1;
         exp_conf_hs++;
         exp_cmd_hs++;
      end
      tick();
      ins_valid = 1'b0;
   endtask

   task automatic run_beats(input int n);
      for (int i = 0; i < n; i++) begin
         ddr_wr_beat = 1'b1;
         @(negedge clk);
         check_output("no_pulse_during_beats", tx_done_pulse, 0);
         tick();
      end
      ddr_wr_beat = 1'b0;
   endtask

   // The current cycle must be the DONE cycle; the following one must be IDLE.
   task automatic expect_done(input logic [3:0] op, input logic [5:0] b);
      @(negedge clk);
      check_output("done_pulse", tx_done_pulse, 1);
      check_output("done_opcode", tx_done_opcode, op);
      check_output("done_buf_id", tx_done_buf_id, b);
      check_output("ready_in_done", ins_ready, 0);
      exp_pulses++;
      tick();
      @(negedge clk);
      check_output("pulse_one_cycle", tx_done_pulse, 0);
      check_output("ready_after_done", ins_ready, 1);
      check_output("opcode_held", tx_done_opcode, op);
      tick();
   endtask

   // Bounded search for the done strobe, then the same tail checks.
   task automatic wait_pulse(input int max_cycles, input logic [3:0] op,
                             input logic [5:0] b, input string name);
      logic found;
      found = 1'b0;
      for (int i = 0; i < max_cycles && !found; i++) begin
         @(negedge clk);
         if (tx_done_pulse) found = 1'b1;
         else tick();
      end
      check_output(name, found, 1);
      if (found) begin
         check_output("wait_opcode", tx_done_opcode, op);
         check_output("wait_buf_id", tx_done_buf_id, b);
         exp_pulses++;
         tick();
         @(negedge clk);
         check_output("wait_ready_after", ins_ready, 1);
         check_output("wait_pulse_low", tx_done_pulse, 0);
      end
      tick();
   endtask

   // Every-cycle comparison of the DUT against the transaction model.
   always @(negedge clk) begin
      if (cmp_en) begin
         if (!conf_allowed) check_output("conf_valid_unexpected", obuf_conf_valid, 0);
         if (!cmd_allowed)  check_output("cmd_valid_unexpected", ddr_wr_cmd_valid, 0);
         if (obuf_conf_valid) begin
            check_output("conf_mode", obuf_conf_mode, m_mode);
            check_output("conf_mask", obuf_conf_mask, m_mask);
            check_output("conf_trans_num", obuf_conf_trans_num, m_trans);
            if (obuf_conf_ready) begin
               conf_allowed = 1'b0;
               conf_hs_seen++;
            end
         end
         if (ddr_wr_cmd_valid) begin
            check_output("cmd_addr", ddr_wr_addr, m_addr);
            check_output("cmd_len", ddr_wr_len, m_trans);
            if (ddr_wr_cmd_ready) begin
               cmd_allowed = 1'b0;
               cmd_hs_seen++;
            end
         end
`ifndef TX_TIMEOUT_EN
         check_output("tx_error_low", tx_error, 0);
`endif
         if (tx_done_pulse) begin
            pulse_seen++;
            check_output("pulse_opcode", tx_done_opcode, m_op);
            check_output("pulse_buf_id", tx_done_buf_id, m_buf);
         end
      end
   end

   initial begin
      #200_000;
      $display("[TB] FAIL watchdog: got no end of test, required completion");
      $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int stray;
      rst              = 1'b1;
      layer_type       = 4'd0;
      ins_valid        = 1'b0;
      ins              = '0;
      obuf_conf_ready  = 1'b1;
      ddr_wr_cmd_ready = 1'b1;
      ddr_wr_beat      = 1'b0;
      repeat (3) tick();

      // Reset state
      @(negedge clk);
      check_output("rst_ins_ready", ins_ready, 1);
      check_output("rst_conf_valid", obuf_conf_valid, 0);
      check_output("rst_cmd_valid", ddr_wr_cmd_valid, 0);
      check_output("rst_pulse", tx_done_pulse, 0);
      check_output("rst_error", tx_error, 0);
      check_output("rst_mask", obuf_conf_mask, 0);
      check_output("rst_addr", ddr_wr_addr, 0);
      check_output("rst_len", ddr_wr_len, 0);
      tick();
      rst    = 1'b0;
      cmp_en = 1'b1;
      tick();

      // Single-PE transfer of 8 beats
      apply_stimulus(4'h1, 4'h3, 6'd5, 12'd8, 32'h0000_1000);
      @(negedge clk);
      check_output("t1_conf_valid", obuf_conf_valid, 1);
      check_output("t1_cmd_valid", ddr_wr_cmd_valid, 1);
      check_output("t1_mask", obuf_conf_mask, 32'h0000_0020);
      check_output("t1_trans_num", obuf_conf_trans_num, 16'd8);
      check_output("t1_len", ddr_wr_len, 16'd8);
      check_output("t1_addr", ddr_wr_addr, 32'h0000_1000);
      check_output("t1_ready_busy", ins_ready, 0);
      tick();
      run_beats(8);
      expect_done(4'h3, 6'd5);

      // Group masks at and past the top of the PE array
      apply_stimulus(4'h0, 4'h2, 6'd7, 12'd1, 32'h0000_2000);
      @(negedge clk);
      check_output("t2_mask_top", obuf_conf_mask, 32'hF000_0000);
      tick();
      run_beats(1);
      expect_done(4'h2, 6'd7);
      apply_stimulus(4'h0, 4'h2, 6'd8, 12'd1, 32'h0000_2100);
      @(negedge clk);
      check_output("t2_mask_over", obuf_conf_mask, 32'h0);
      tick();
      run_beats(1);
      expect_done(4'h2, 6'd8);
      apply_stimulus(4'hE, 4'h2, 6'd40, 12'd1, 32'h0000_2200);
      @(negedge clk);
      check_output("t2_single_over", obuf_conf_mask, 32'h0);
      check_output("t2_mode", obuf_conf_mode, 4'hE);
      tick();
      run_beats(1);
      expect_done(4'h2, 6'd40);

      // Zero-length instruction
      apply_stimulus(4'h1, 4'h9, 6'd33, 12'd0, 32'hDEAD_0000);
      @(negedge clk);
      check_output("t3_pulse", tx_done_pulse, 1);
      check_output("t3_conf_valid", obuf_conf_valid, 0);
      check_output("t3_cmd_valid", ddr_wr_cmd_valid, 0);
      check_output("t3_opcode", tx_done_opcode, 4'h9);
      exp_pulses++;
      tick();
      @(negedge clk);
      check_output("t3_ready", ins_ready, 1);
      tick();

      // Command ready 3 cycles before config ready, both beats inside CONF
      obuf_conf_ready  = 1'b0;
      ddr_wr_cmd_ready = 1'b0;
      apply_stimulus(4'h1, 4'h4, 6'd2, 12'd2, 32'h2000_0040);
      ddr_wr_cmd_ready = 1'b1;
      ddr_wr_beat      = 1'b1;
      @(negedge clk);
      check_output("t4_conf_v1", obuf_conf_valid, 1);
      check_output("t4_cmd_v1", ddr_wr_cmd_valid, 1);
      tick();
      ddr_wr_cmd_ready = 1'b0;
      @(negedge clk);
      check_output("t4_cmd_v2", ddr_wr_cmd_valid, 0);
      check_output("t4_conf_v2", obuf_conf_valid, 1);
      tick();
      ddr_wr_beat = 1'b0;
      @(negedge clk);
      check_output("t4_conf_v3", obuf_conf_valid, 1);
      check_output("t4_pulse3", tx_done_pulse, 0);
      tick();
      obuf_conf_ready = 1'b1;
      @(negedge clk);
      check_output("t4_pulse4", tx_done_pulse, 0);
      tick();
      @(negedge clk);
      check_output("t4_conf_v5", obuf_conf_valid, 0);
      check_output("t4_pulse5", tx_done_pulse, 0);
      check_output("t4_ready5", ins_ready, 0);
      tick();
      expect_done(4'h4, 6'd2);
      ddr_wr_cmd_ready = 1'b1;

      // Extra beats during CONF must saturate at the target count
      obuf_conf_ready  = 1'b0;
      ddr_wr_cmd_ready = 1'b0;
      apply_stimulus(4'h1, 4'h5, 6'd9, 12'd1, 32'h3000_0000);
      ddr_wr_beat = 1'b1;
      repeat (3) tick();
      ddr_wr_beat      = 1'b0;
      obuf_conf_ready  = 1'b1;
      ddr_wr_cmd_ready = 1'b1;
      wait_pulse(10, 4'h5, 6'd9, "t4b_pulse_found");

      // Beats in IDLE, including the handshake cycle, are not counted
      ddr_wr_beat = 1'b1;
      repeat (3) tick();
      apply_stimulus(4'h1, 4'h8, 6'd11, 12'd2, 32'h4000_0000);
      ddr_wr_beat = 1'b0;
      tick();
      run_beats(1);
      @(negedge clk);
      check_output("t5_no_early_done", tx_done_pulse, 0);
      tick();
      run_beats(1);
      expect_done(4'h8, 6'd11);

      // Reset in the middle of a transfer abandons it
      apply_stimulus(4'h1, 4'h6, 6'd1, 12'd8, 32'h5000_0000);
      tick();
      run_beats(3);
      rst = 1'b1;
      tick();
      rst          = 1'b0;
      conf_allowed = 1'b0;
      cmd_allowed  = 1'b0;
      @(negedge clk);
      check_output("t6_ready", ins_ready, 1);
      check_output("t6_pulse", tx_done_pulse, 0);
      check_output("t6_mask", obuf_conf_mask, 0);
      check_output("t6_addr", ddr_wr_addr, 0);
      check_output("t6_mode", obuf_conf_mode, 0);
      check_output("t6_opcode", tx_done_opcode, 0);
      check_output("t6_buf_id", tx_done_buf_id, 0);
      repeat (5) tick();
      apply_stimulus(4'h0, 4'h7, 6'd3, 12'd3, 32'h6000_0000);
      @(negedge clk);
      check_output("t6_group_mask", obuf_conf_mask, 32'h0000_F000);
      tick();
      run_beats(3);
      expect_done(4'h7, 6'd3);

      // No beats for longer than the watchdog interval
      apply_stimulus(4'h1, 4'hA, 6'd20, 12'd2, 32'h7000_0000);
      @(negedge clk);
      check_output("t7_mask", obuf_conf_mask, 32'h0010_0000);
      tick();
`ifdef TX_TIMEOUT_EN
      wait_pulse(1100, 4'hA, 6'd20, "t7_timeout_pulse");
      @(negedge clk);
      check_output("t7_error_set", tx_error, 1);
      tick();
`else
      stray = 0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         if (tx_done_pulse) stray++;
         tick();
      end
      check_output("t7_no_timeout_pulse", stray, 0);
      check_output("t7_still_busy", ins_ready, 0);
      check_output("t7_error_low", tx_error, 0);
      run_beats(2);
      expect_done(4'hA, 6'd20);
`endif

      repeat (3) tick();
      cmp_en = 1'b0;
      check_output("total_conf_handshakes", conf_hs_seen, exp_conf_hs);
      check_output("total_cmd_handshakes", cmd_hs_seen, exp_cmd_hs);
      check_output("total_done_pulses", pulse_seen, exp_pulses);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
